carregador_programa: RTL and testbench

- Upstream stage of the computer top. Receives a program over a UART serial line and writes it into instruction memory through the external write port.
- Drives `mem_wr`, `mem_in` and `endereco_ext`.
- Holds the processor in reset while a load is in progress and releases it when the load completes.
- Sits between the board RX pin and the computer's external memory port.

---
 rtl/carregador_programa_pkg.sv | 26 ++
 rtl/carregador_programa_if.sv | 20 ++
 rtl/carregador_programa_receptor_uart.sv | 102 ++++++++++
 rtl/carregador_programa.sv | 127 ++++++++++++
 tb/tb_carregador_programa.sv | 235 +++++++++++++++++++++++
 5 files changed

// File: rtl/carregador_programa_pkg.sv
// rtl/carregador_programa_pkg.sv - shared state encodings and UART frame constants for the program loader
package carregador_programa_pkg;

  localparam logic [3:0] OCIOSO  = 4'd0;
  localparam logic [3:0] CONT_H  = 4'd1;
  localparam logic [3:0] CONT_L  = 4'd2;
  localparam logic [3:0] DADO_H  = 4'd3;
  localparam logic [3:0] DADO_L  = 4'd4;
  localparam logic [3:0] ESCRITA = 4'd5;
  localparam logic [3:0] CHECK   = 4'd6;
  localparam logic [3:0] FIM     = 4'd7;
  localparam logic [3:0] ERRO    = 4'd8;

  localparam logic [1:0] RX_OCIOSO = 2'd0;
  localparam logic [1:0] RX_INICIO = 2'd1;
  localparam logic [1:0] RX_DADOS  = 2'd2;
  localparam logic [1:0] RX_PARADA = 2'd3;

  localparam int   UART_DATA_BITS  = 8;
  localparam logic UART_STOP_LEVEL = 1'b1;

  function automatic logic [15:0] junta_palavra(input logic [7:0] alto, input logic [7:0] baixo);
    return {alto, baixo};
  endfunction

endpackage

// File: rtl/carregador_programa_if.sv
// rtl/carregador_programa_if.sv - serial input and instruction-memory write port of the program loader
interface carregador_programa_if;
  logic        rx;
  logic        mem_wr;
  logic [15:0] mem_in;
  logic [15:0] endereco_ext;
  logic        segura_proc;
  logic        pronto;
  logic        erro;

  modport master (
    input  rx,
    output mem_wr, mem_in, endereco_ext, segura_proc, pronto, erro
  );

  modport slave (
    output rx,
    input  mem_wr, mem_in, endereco_ext, segura_proc, pronto, erro
  );
endinterface

// File: rtl/carregador_programa_receptor_uart.sv
// rtl/carregador_programa_receptor_uart.sv - 8N1 UART receiver with input synchronizer and glitch-rejecting start check
module receptor_uart
  import carregador_programa_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       rx,
  output logic       byte_ok,
  output logic [7:0] dado,
  output logic       erro_quadro
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] FIM_BIT  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] MEIO_BIT = CW'(CLKS_PER_BIT / 2 - 1);

  logic          r_sync1;
  logic          r_sync2;
  logic          r_prev;
  logic [1:0]    r_estado;
  logic [CW-1:0] r_cnt;
  logic [2:0]    r_nbit;
  logic [7:0]    r_shift;
  logic [7:0]    r_dado;
  logic          r_byte_ok;
  logic          r_erro_quadro;
  logic          w_rx;

  assign w_rx        = r_sync2;
  assign byte_ok     = r_byte_ok;
  assign dado        = r_dado;
  assign erro_quadro = r_erro_quadro;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_sync1       <= 1'b1;
      r_sync2       <= 1'b1;
      r_prev        <= 1'b1;
      r_estado      <= RX_OCIOSO;
      r_cnt         <= '0;
      r_nbit        <= '0;
      r_shift       <= '0;
      r_dado        <= '0;
      r_byte_ok     <= 1'b0;
      r_erro_quadro <= 1'b0;
    end else begin
      r_sync1       <= rx;
      r_sync2       <= r_sync1;
      r_prev        <= r_sync2;
      r_byte_ok     <= 1'b0;
      r_erro_quadro <= 1'b0;
      case (r_estado)
        RX_OCIOSO: begin
          if (r_prev && !w_rx) begin
            r_estado <= RX_INICIO;
            r_cnt    <= '0;
          end
        end
        RX_INICIO: begin
          // a start bit that is high again at mid-bit was only a glitch
          if (r_cnt == MEIO_BIT) begin
            r_cnt  <= '0;
            r_nbit <= '0;
            r_estado <= w_rx ? RX_OCIOSO : RX_DADOS;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        RX_DADOS: begin
          if (r_cnt == FIM_BIT) begin
            r_cnt   <= '0;
            r_shift <= {w_rx, r_shift[7:1]};
            if (r_nbit == 3'(UART_DATA_BITS - 1)) begin
              r_estado <= RX_PARADA;
            end else begin
              r_nbit <= r_nbit + 1'b1;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: begin
          if (r_cnt == FIM_BIT) begin
            r_cnt    <= '0;
            r_estado <= RX_OCIOSO;
            if (w_rx == UART_STOP_LEVEL) begin
              r_byte_ok <= 1'b1;
              r_dado    <= r_shift;
            end else begin
              r_erro_quadro <= 1'b1;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: rtl/carregador_programa.sv
// rtl/carregador_programa.sv - UART program loader writing words into instruction memory; holds the CPU until done
// Optional trailing XOR checksum byte enabled by defining CARREGADOR_CHECKSUM_EN.
module carregador_programa
  import carregador_programa_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int ADDR_W       = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  carregador_programa_if.master bus
);

`ifdef CARREGADOR_CHECKSUM_EN
  localparam logic [3:0] APOS_CARGA = CHECK;
`else
  localparam logic [3:0] APOS_CARGA = FIM;
`endif

  logic              w_byte_ok;
  logic [7:0]        w_dado;
  logic              w_erro_quadro;

  logic [3:0]        r_estado;
  logic [15:0]       r_n;
  logic [15:0]       r_cnt;
  logic [ADDR_W-1:0] r_addr;
  logic [7:0]        r_alto;
  logic              r_mem_wr;
  logic [15:0]       r_mem_in;
  logic [15:0]       r_endereco;
`ifdef CARREGADOR_CHECKSUM_EN
  logic [7:0]        r_xor;
`endif

  receptor_uart #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_rx (
    .clock       (clock),
    .reset       (reset),
    .rx          (bus.rx),
    .byte_ok     (w_byte_ok),
    .dado        (w_dado),
    .erro_quadro (w_erro_quadro)
  );

  assign bus.mem_wr       = r_mem_wr;
  assign bus.mem_in       = r_mem_in;
  assign bus.endereco_ext = r_endereco;
  assign bus.pronto       = (r_estado == FIM);
  assign bus.segura_proc  = (r_estado != FIM);
  assign bus.erro         = (r_estado == ERRO);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_estado   <= OCIOSO;
      r_n        <= '0;
      r_cnt      <= '0;
      r_addr     <= '0;
      r_alto     <= '0;
      r_mem_wr   <= 1'b0;
      r_mem_in   <= '0;
      r_endereco <= '0;
`ifdef CARREGADOR_CHECKSUM_EN
      r_xor      <= '0;
`endif
    end else begin
      r_mem_wr <= 1'b0;
`ifdef CARREGADOR_CHECKSUM_EN
      if (w_byte_ok && r_estado != FIM && r_estado != ERRO && r_estado != CHECK) begin
        r_xor <= r_xor ^ w_dado;
      end
`endif
      // a completed load is final: line activity after FIM cannot turn it into an error
      if (w_erro_quadro && r_estado != FIM) begin
        r_estado <= ERRO;
      end else begin
        case (r_estado)
          OCIOSO: begin
            if (w_byte_ok) begin
              r_n[15:8] <= w_dado;
              r_estado  <= CONT_H;
            end
          end
          CONT_H: begin
            if (w_byte_ok) begin
              r_n[7:0] <= w_dado;
              r_estado <= ({r_n[15:8], w_dado} == 16'd0) ? APOS_CARGA : CONT_L;
            end
          end
          CONT_L: r_estado <= DADO_H;
          DADO_H: begin
            if (w_byte_ok) begin
              r_alto   <= w_dado;
              r_estado <= DADO_L;
            end
          end
          DADO_L: begin
            // outputs are registered here so the strobe lands one cycle after the low byte
            if (w_byte_ok) begin
              r_mem_wr   <= 1'b1;
              r_mem_in   <= junta_palavra(r_alto, w_dado);
              r_endereco <= 16'(r_addr);
              r_estado   <= ESCRITA;
            end
          end
          ESCRITA: begin
            r_addr   <= r_addr + 1'b1;
            r_cnt    <= r_cnt + 16'd1;
            r_estado <= (16'(r_cnt + 16'd1) == r_n) ? APOS_CARGA : DADO_H;
          end
`ifdef CARREGADOR_CHECKSUM_EN
          CHECK: begin
            if (w_byte_ok) begin
              r_estado <= (w_dado == r_xor) ? FIM : ERRO;
            end
          end
`endif
          FIM:     r_estado <= FIM;
          ERRO:    r_estado <= ERRO;
          default: r_estado <= ERRO;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_carregador_programa.sv
// tb/tb_carregador_programa.sv - directed scoreboard bench for carregador_programa (CLKS_PER_BIT=4)
module tb_carregador_programa;

  localparam int CPB = 4;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  carregador_programa_if bus();

  carregador_programa #(
    .CLKS_PER_BIT(CPB),
    .ADDR_W      (16)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int          checks = 0;
  int          errors = 0;
  int          n_writes = 0;
  int          n_bytes = 0;
  logic [31:0] exp_q[$];
  logic [7:0]  tb_xor;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clock) begin
    if (dut.u_rx.byte_ok) n_bytes++;
    if (bus.mem_wr) begin
      n_writes++;
      checks++;
      assert (exp_q.size() != 0) else begin
        errors++;
        $error("FAIL unexpected_write observed=%0h@%0h expected=none", bus.mem_in, bus.endereco_ext);
      end
      if (exp_q.size() != 0) begin
        logic [31:0] e;
        e = exp_q.pop_front();
        checks++;
        assert ({bus.endereco_ext, bus.mem_in} === e) else begin
          errors++;
          $error("FAIL write observed=%0h@%0h expected=%0h@%0h", bus.mem_in, bus.endereco_ext, e[15:0], e[31:16]);
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    tb_xor = tb_xor ^ b;
    bus.rx = 1'b0;
    tick(CPB);
    for (int i = 0; i < 8; i++) begin
      bus.rx = b[i];
      tick(CPB);
    end
    bus.rx = stop;
    tick(CPB);
    bus.rx = 1'b1;
    tick(2);
  endtask

  task automatic send_count(input logic [15:0] n);
    tb_xor = 8'h00;
    send_byte(n[15:8], 1'b1);
    send_byte(n[7:0], 1'b1);
  endtask

  task automatic send_word(input logic [15:0] w, input logic [15:0] addr);
    send_byte(w[15:8], 1'b1);
    exp_q.push_back({addr, w});
    send_byte(w[7:0], 1'b1);
  endtask

  task automatic finish_load();
`ifdef CARREGADOR_CHECKSUM_EN
    logic [7:0] x;
    x = tb_xor;
    send_byte(x, 1'b1);
`endif
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    exp_q.delete();
    tick(2);
  endtask

  task automatic wait_flag(input string tag, input bit use_erro);
    int i;
    for (i = 0; i < 200; i++) begin
      @(negedge clock);
      if ((use_erro ? bus.erro : bus.pronto) === 1'b1) break;
    end
    chk(tag, use_erro ? bus.erro : bus.pronto, 1);
  endtask

  initial begin
    int w0;
    bus.rx = 1'b1;
    tb_xor = 8'h00;
    tick(3);
    reset = 1'b0;
    @(negedge clock);
    chk("rst_mem_wr", bus.mem_wr, 0);
    chk("rst_mem_in", bus.mem_in, 0);
    chk("rst_endereco", bus.endereco_ext, 0);
    chk("rst_segura", bus.segura_proc, 1);
    chk("rst_pronto", bus.pronto, 0);
    chk("rst_erro", bus.erro, 0);

    // one-cycle low glitch while idle
    tick(1);
    bus.rx = 1'b0;
    tick(1);
    bus.rx = 1'b1;
    tick(20);
    chk("glitch_bytes", n_bytes, 0);
    chk("glitch_pronto", bus.pronto, 0);
    chk("glitch_erro", bus.erro, 0);
    chk("glitch_segura", bus.segura_proc, 1);

    // two-word load
    send_count(16'h0002);
    send_word(16'h1234, 16'd0);
    chk("load2_segura_mid", bus.segura_proc, 1);
    send_word(16'hABCD, 16'd1);
    finish_load();
    wait_flag("load2_pronto", 1'b0);
    chk("load2_segura", bus.segura_proc, 0);
    chk("load2_erro", bus.erro, 0);
    chk("load2_writes", n_writes, 2);
    chk("hold_mem_in", bus.mem_in, 16'hABCD);
    chk("hold_endereco", bus.endereco_ext, 1);
    send_byte(8'h55, 1'b1);
    send_byte(8'h66, 1'b0);
    tick(4);
    chk("fim_ignore_pronto", bus.pronto, 1);
    chk("fim_ignore_erro", bus.erro, 0);
    chk("fim_ignore_writes", n_writes, 2);
    do_reset();
    chk("reset_segura", bus.segura_proc, 1);

    // N = 0: pronto right after the count-low byte
    fork
      send_count(16'h0000);
      begin
        int seen;
        seen = 0;
        for (int i = 0; i < 400 && seen < 2; i++) begin
          @(negedge clock);
          if (dut.u_rx.byte_ok) seen++;
        end
        chk("n0_bytes_seen", seen, 2);
        chk("n0_pronto_at_byte", bus.pronto, 0);
        @(negedge clock);
`ifdef CARREGADOR_CHECKSUM_EN
        chk("n0_pronto_next", bus.pronto, 0);
`else
        chk("n0_pronto_next", bus.pronto, 1);
`endif
      end
    join
    finish_load();
    wait_flag("n0_pronto", 1'b0);
    chk("n0_writes", n_writes, 2);
    do_reset();

    // framing error on the third byte
    send_count(16'h0001);
    send_byte(8'h12, 1'b0);
    tick(4);
    chk("frame_erro", bus.erro, 1);
    chk("frame_pronto", bus.pronto, 0);
    chk("frame_segura", bus.segura_proc, 1);
    send_byte(8'h34, 1'b1);
    tick(4);
    chk("frame_sticky", bus.erro, 1);
    chk("frame_writes", n_writes, 2);
    do_reset();
    chk("frame_reset_erro", bus.erro, 0);

    // reset in the middle of a three-word load, then reload from address 0
    send_count(16'h0003);
    w0 = n_writes;
    send_word(16'h1111, 16'd0);
    tick(3);
    chk("midload_writes", n_writes, w0 + 1);
    send_byte(8'h22, 1'b1);
    do_reset();
    chk("midload_pronto", bus.pronto, 0);
    send_count(16'h0001);
    send_word(16'h00FF, 16'd0);
    finish_load();
    wait_flag("reload_pronto", 1'b0);
    chk("reload_writes", n_writes, w0 + 2);
    do_reset();

`ifdef CARREGADOR_CHECKSUM_EN
    send_count(16'h0001);
    send_word(16'h1234, 16'd0);
    send_byte(8'h27, 1'b1);
    wait_flag("cks_good_pronto", 1'b0);
    chk("cks_good_erro", bus.erro, 0);
    do_reset();
    send_count(16'h0001);
    send_word(16'h1234, 16'd0);
    send_byte(8'h28, 1'b1);
    wait_flag("cks_bad_erro", 1'b1);
    chk("cks_bad_pronto", bus.pronto, 0);
    do_reset();
`endif

    tick(10);
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
